led_fade_engine: RTL
====================

Name: led_fade_engine

Overview:
- Per-LED brightness envelope generator for the front-panel LED PWM stage.
- Directly upstream of the LED PWM comparator; produces the packed per-LED brightness bus it consumes.
- Takes the one-hot "currently selected LED" vector and a global slow tick.
- Each channel ramps up fast when selected, holds, then fades out slowly, giving a trailing-glow sweep.

Parameters:
- NUM_LED, 8: number of LED channels.
- PWM_W, 5: brightness width per channel.
- MAX_LEVEL, 31: full-brightness level. Must satisfy 1 <= MAX_LEVEL <= 2^PWM_W-1.
- ATTACK_STEP, 8: level increment per tick while in ATTACK. Must be >= 1.
- DECAY_STEP, 1: level decrement per tick while in DECAY. Must be >= 1.
- HOLD_TICKS, 2: number of unselected ticks spent in HOLD before DECAY. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- selected  in  NUM_LED  one-hot (or zero) LED select; bit i is channel i.
- tick  in  1  single-cycle step strobe; every high cycle counts as one tick.
- pwm  out  PWM_W*NUM_LED  packed brightness; channel i is at bits [(i+1)*PWM_W-1 : i*PWM_W].
- active  out  NUM_LED  channel i is not in IDLE.
- busy  out  1  OR-reduction of active.

Behaviour:
- Reset: while rst_n=0 at a clock edge, every channel goes to IDLE with level=0 and hold_cnt=0. On the following cycle pwm=0, active=0 and busy=0. Reset mid-operation discards all channel state.
- Outputs are registered. pwm, active and busy reflect the state updated by the tick that occurred on the previous cycle (latency 1 clock).
- State changes only on cycles where tick=1. selected is sampled only on tick cycles; it is ignored otherwise.
- Arithmetic is done in PWM_W+1 bits.
  - Increment saturates at MAX_LEVEL.
  - Decrement saturates at 0.
  - No wrap-around is permitted.
- Per-channel FSM (values below are applied on a tick cycle):
  - IDLE: if sel, set level=sat(0+ATTACK_STEP). Go to HOLD with hold_cnt=0 if the new level equals MAX_LEVEL, else go to ATTACK. If not sel, stay in IDLE with level=0.
  - ATTACK: set level=sat(level+ATTACK_STEP) regardless of sel; the ramp is committed once started. When the new level equals MAX_LEVEL, go to HOLD with hold_cnt=0.
  - HOLD: level stays at MAX_LEVEL.
    - If sel, set hold_cnt=0.
    - If not sel, set hold_cnt=hold_cnt+1.
    - When the incremented hold_cnt equals HOLD_TICKS, go to DECAY.
  - DECAY:
    - If sel, set level=sat(level+ATTACK_STEP) and go to ATTACK, or to HOLD if the new level equals MAX_LEVEL.
    - If not sel, set level=sat(level-DECAY_STEP). When the new level is 0, go to IDLE.
- active[i] = (state != IDLE). busy = |active.
- Several selected bits high at once: each channel acts independently; this is legal.
- selected=0: all channels continue their envelopes.
- Illegal parameter values cause an elaboration-time error: ATTACK_STEP=0, DECAY_STEP=0, HOLD_TICKS=0, or MAX_LEVEL out of range.

Decomposition:
- Shared package holds:
  - the state encoding typedef: IDLE, ATTACK, HOLD, DECAY (2 bits);
  - the saturating add/subtract helper functions;
  - the default parameter constants.
- One sub-module, led_fade_ch, implements a single channel's FSM, level register and hold counter.
- led_fade_engine is a generate loop over NUM_LED instances of led_fade_ch, plus the output packing and the busy reduction.

Test Plan:
All scenarios use the default parameters.
1. Reset: hold rst_n=0 with tick=1 and selected=8'hFF -> pwm=0, active=0 and busy=0 on the cycle after any reset edge.
2. Single pulse: selected=8'h01 on tick 1 only ->
   - ch0 level after ticks 1..4 is 8, 16, 24, 31 (HOLD at tick 4);
   - HOLD through ticks 5 and 6 (DECAY entered at tick 6);
   - levels 30 down to 0 over ticks 7..37;
   - IDLE with active[0]=0 after tick 37;
   - all other channels stay 0.
3. Reselect in DECAY: ch3 decaying at level 20, selected=8'h08 on the next tick -> level 28, then 31 (HOLD) on the following tick, even with sel low.
4. Extended hold: ch5 kept selected for 10 ticks after reaching 31 -> stays 31 in HOLD. After release, DECAY begins at the 2nd unselected tick and the level is 30 one tick later.
5. Back-to-back ticks: tick high 3 consecutive cycles with selected=8'h80 on all three -> ch7 level 8, 16, 24 on successive cycles. selected toggled without tick -> no change.
6. Reset mid-operation: rst_n=0 for one cycle while ch2 is at level 17 in DECAY -> pwm=0, active=0 next cycle. The next selected tick restarts ch2 at 8.

Source files
------------

// File: rtl/led_fade_engine_pkg.sv
// Shared types, default parameters and saturating arithmetic helpers
// for the front-panel LED fade engine.
package led_fade_engine_pkg;

   localparam int unsigned DEF_NUM_LED     = 8;
   localparam int unsigned DEF_PWM_W       = 5;
   localparam int unsigned DEF_MAX_LEVEL   = 31;
   localparam int unsigned DEF_ATTACK_STEP = 8;
   localparam int unsigned DEF_DECAY_STEP  = 1;
   localparam int unsigned DEF_HOLD_TICKS  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ATTACK = 2'd1,
      ST_HOLD   = 2'd2,
      ST_DECAY  = 2'd3
   } fade_state_e;

   // Operands are level-sized, so 32-bit sums never wrap.
   function automatic int unsigned sat_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned max_v);
      int unsigned sum;
      sum = a + b;
      return (sum > max_v) ? max_v : sum;
   endfunction

   function automatic int unsigned sat_sub(input int unsigned a,
                                           input int unsigned b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: attack/hold/decay envelope FSM with level register
// and hold counter, advanced only on tick cycles.
module led_fade_ch
   import led_fade_engine_pkg::*;
#(
   parameter int unsigned PWM_W       = DEF_PWM_W,
   parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
   parameter int unsigned ATTACK_STEP = DEF_ATTACK_STEP,
   parameter int unsigned DECAY_STEP  = DEF_DECAY_STEP,
   parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel,
   input  logic             tick,
   output logic [PWM_W-1:0] level,
   output logic             active,
   output logic             active_next_c
);

   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam logic [PWM_W-1:0] MAX_LV = PWM_W'(MAX_LEVEL);

   fade_state_e       state_q, state_d;
   logic [PWM_W-1:0]  level_q, level_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   logic [PWM_W-1:0]  up_lvl, dn_lvl;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         hold_q  <= '0;
         active  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         hold_q  <= hold_d;
         active  <= active_next_c;
      end
   end

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      hold_d   = hold_q;
      up_lvl   = PWM_W'(sat_add(32'(level_q), ATTACK_STEP, MAX_LEVEL));
      dn_lvl   = PWM_W'(sat_sub(32'(level_q), DECAY_STEP));
      hold_inc = hold_q + HOLD_W'(1);

      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (sel) begin
                  level_d = PWM_W'(sat_add(32'd0, ATTACK_STEP, MAX_LEVEL));
                  if (level_d == MAX_LV) begin
                     state_d = ST_HOLD;
                     hold_d  = '0;
                  end else begin
                     state_d = ST_ATTACK;
                  end
               end else begin
                  level_d = '0;
               end
            end
            // Ramp is committed once started; sel is not consulted.
            ST_ATTACK: begin
               level_d = up_lvl;
               if (up_lvl == MAX_LV) begin
                  state_d = ST_HOLD;
                  hold_d  = '0;
               end
            end
            ST_HOLD: begin
               level_d = MAX_LV;
               if (sel) begin
                  hold_d = '0;
               end else begin
                  hold_d = hold_inc;
                  if (32'(hold_inc) == HOLD_TICKS) state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (sel) begin
                  level_d = up_lvl;
                  if (up_lvl == MAX_LV) begin
                     state_d = ST_HOLD;
                     hold_d  = '0;
                  end else begin
                     state_d = ST_ATTACK;
                  end
               end else begin
                  level_d = dn_lvl;
                  if (dn_lvl == '0) state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      active_next_c = (state_d != ST_IDLE);
   end

   assign level = level_q;

endmodule

// File: rtl/led_fade_engine.sv
// Trailing-glow brightness generator: NUM_LED independent fade channels
// packed onto the PWM comparator bus, plus a registered any-active flag.
module led_fade_engine
   import led_fade_engine_pkg::*;
#(
   parameter int unsigned NUM_LED     = DEF_NUM_LED,
   parameter int unsigned PWM_W       = DEF_PWM_W,
   parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
   parameter int unsigned ATTACK_STEP = DEF_ATTACK_STEP,
   parameter int unsigned DECAY_STEP  = DEF_DECAY_STEP,
   parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_LED-1:0]       selected,
   input  logic                     tick,
   output logic [PWM_W*NUM_LED-1:0] pwm,
   output logic [NUM_LED-1:0]       active,
   output logic                     busy
);

   if (ATTACK_STEP == 0 || DECAY_STEP == 0 || HOLD_TICKS == 0 ||
       MAX_LEVEL < 1 || MAX_LEVEL > ((32'd1 << PWM_W) - 32'd1)) begin : g_bad_param
      $error("led_fade_engine: illegal parameter combination");
   end

   logic [NUM_LED-1:0] active_next;

   for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
      led_fade_ch #(
         .PWM_W       (PWM_W),
         .MAX_LEVEL   (MAX_LEVEL),
         .ATTACK_STEP (ATTACK_STEP),
         .DECAY_STEP  (DECAY_STEP),
         .HOLD_TICKS  (HOLD_TICKS)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .sel           (selected[i]),
         .tick          (tick),
         .level         (pwm[i*PWM_W +: PWM_W]),
         .active        (active[i]),
         .active_next_c (active_next[i])
      );
   end

   // Registered from next-state so busy lines up with active.
   always_ff @(posedge clk) begin
      if (!rst_n) busy <= 1'b0;
      else        busy <= |active_next;
   end

endmodule
